// File: rtl/smi_header_insert_pf1.sv
// Prepends a HeadWidth-byte header to each SMI frame; optional SMI_HEADER_INSERT_ZERO_PAD_EN zeroes bytes past eofc.
// Latency 2 clk capture-to-output; Stop on each input asserts while its register is held; output FIFO absorbs smiOutStop.
module smi_header_insert_pf1 #(
  parameter int FlitWidth     = 16,
  parameter int HeadWidth     = 4,
  parameter int FifoSize      = 16,
  parameter int FifoIndexSize = 4,
  parameter int FlitSplit     = FlitWidth - HeadWidth
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   headerReady,
  input  logic [HeadWidth*8-1:0] headerData,
  output logic                   headerStop,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth*8-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop
);
  localparam int DataW      = FlitWidth * 8;
  localparam int HeadW      = HeadWidth * 8;
  localparam int SplitW     = FlitSplit * 8;
  localparam int MemDepth   = FifoSize - 1;
  localparam int LastIdxI   = MemDepth - 1;
  localparam int EofcMaskI  = 2 * FlitWidth - 1;
  localparam logic [7:0] EofcMask   = EofcMaskI[7:0];
  localparam logic [7:0] SplitBytes = FlitSplit[7:0];
  localparam logic [7:0] HeadBytes  = HeadWidth[7:0];
  localparam logic [FifoIndexSize-1:0] LastIdx = LastIdxI[FifoIndexSize-1:0];
  localparam logic [FifoIndexSize:0]   FullCnt = MemDepth[FifoIndexSize:0];

  typedef enum logic [1:0] {IDLE, COPY, TAIL} state_t;

  logic             hdr_vld;
  logic [HeadW-1:0] hdr_dat;
  logic             in_vld;
  logic [7:0]       in_eofc;
  logic [DataW-1:0] in_dat;
  logic             hdr_take;
  logic             in_take;

  state_t           state, state_nxt;
  logic [HeadW-1:0] carry, carry_nxt;
  logic [7:0]       last_eofc, last_nxt;
  logic             push;
  logic [7:0]       push_eofc;
  logic [DataW-1:0] push_raw;
  logic [DataW-1:0] push_dat;
  logic             buf_full;

  logic [DataW+7:0]         mem [MemDepth];
  logic [FifoIndexSize-1:0] wr_ptr, rd_ptr;
  logic [FifoIndexSize:0]   count;
  logic                     pop;

  assign headerStop = hdr_vld & ~hdr_take;
  assign smiInStop  = in_vld & ~in_take;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hdr_vld <= 1'b0;
      hdr_dat <= '0;
      in_vld  <= 1'b0;
      in_eofc <= 8'd0;
      in_dat  <= '0;
    end else begin
      if (!headerStop) begin
        hdr_vld <= headerReady;
        hdr_dat <= headerData;
      end
      if (!smiInStop) begin
        in_vld  <= smiInReady;
        in_eofc <= smiInEofc & EofcMask;
        in_dat  <= smiInData;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      carry     <= '0;
      last_eofc <= 8'd0;
    end else begin
      state     <= state_nxt;
      carry     <= carry_nxt;
      last_eofc <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    carry_nxt = carry;
    last_nxt  = last_eofc;
    push      = 1'b0;
    push_eofc = 8'd0;
    push_raw  = {in_dat[SplitW-1:0], carry};
    hdr_take  = 1'b0;
    in_take   = 1'b0;
    case (state)
      IDLE, COPY: begin
        // A frame starts only once header and first flit are both registered.
        if (in_vld && !buf_full && (state == COPY || hdr_vld)) begin
          push      = 1'b1;
          in_take   = 1'b1;
          hdr_take  = (state == IDLE);
          if (state == IDLE) push_raw = {in_dat[SplitW-1:0], hdr_dat};
          carry_nxt = in_dat[DataW-1 -: HeadW];
          if (in_eofc == 8'd0) begin
            state_nxt = COPY;
          end else if (in_eofc <= SplitBytes) begin
            push_eofc = in_eofc + HeadBytes;
            state_nxt = IDLE;
          end else begin
            last_nxt  = in_eofc;
            state_nxt = TAIL;
          end
        end
      end
      TAIL: begin
        if (!buf_full) begin
          push      = 1'b1;
          push_eofc = last_eofc - SplitBytes;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push_dat = push_raw;
`ifdef SMI_HEADER_INSERT_ZERO_PAD_EN
    for (int b = 0; b < FlitWidth; b++) begin
      if (push_eofc != 8'd0 && 8'(b) >= push_eofc) push_dat[b*8 +: 8] = 8'h00;
    end
`endif
  end

  // The output register acts as the last FIFO slot, so memory holds FifoSize-1 entries.
  assign buf_full = (count == FullCnt);
  assign pop      = (count != '0) && (!smiOutReady || !smiOutStop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_dat, push_eofc};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      smiOutReady <= 1'b0;
      smiOutEofc  <= 8'd0;
      smiOutData  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LastIdx) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LastIdx) ? '0 : rd_ptr + 1'b1;
      count <= count + {{FifoIndexSize{1'b0}}, push} - {{FifoIndexSize{1'b0}}, pop};
      if (pop) begin
        smiOutReady              <= 1'b1;
        {smiOutData, smiOutEofc} <= mem[rd_ptr];
      end else if (!smiOutStop) begin
        smiOutReady <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_smi_header_insert_pf1.sv
// Bench for smi_header_insert_pf1: frames are modelled as a byte stream (header + payload) cut into flits.
module tb_smi_header_insert_pf1;
  localparam int FW = 16;
  localparam int HW = 4;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic [FW*8-1:0] dat;
    logic [7:0]      eofc;
  } flit_t;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic            headerReady = 1'b0;
  logic [HW*8-1:0] headerData = '0;
  logic            headerStop;
  logic            smiInReady = 1'b0;
  logic [7:0]      smiInEofc = 8'd0;
  logic [FW*8-1:0] smiInData = '0;
  logic            smiInStop;
  logic            smiOutReady;
  logic [7:0]      smiOutEofc;
  logic [FW*8-1:0] smiOutData;
  logic            smiOutStop = 1'b0;

  smi_header_insert_pf1 #(.FlitWidth(FW), .HeadWidth(HW), .FifoSize(16), .FifoIndexSize(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .headerReady(headerReady), .headerData(headerData), .headerStop(headerStop),
    .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData), .smiInStop(smiInStop),
    .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData), .smiOutStop(smiOutStop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  flit_t           in_q[$];
  flit_t           exp_q[$];
  logic [HW*8-1:0] hdr_q[$];
  flit_t           m_in[$];
  flit_t           m_out[$];

  int pass_cnt = 0;
  int chk_cnt = 0;
  int gap_pct = 0;
  int stop_pct = 0;
  bit eofc_junk = 1'b0;
  int in_cyc = -1;
  int rdy_cyc = -1;
  bit in_xfer = 1'b0;
  bit hdr_xfer = 1'b0;

  task automatic check_i(input string name, input int act, input int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic check_f(input string name, input flit_t act, input flit_t req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [FW*8-1:0] valid_mask(input logic [7:0] e);
    logic [FW*8-1:0] m;
    m = '1;
`ifndef SMI_HEADER_INSERT_ZERO_PAD_EN
    if (e != 8'd0) begin
      for (int b = 0; b < FW; b++) if (b >= int'(e)) m[b*8 +: 8] = 8'h00;
    end
`endif
    return m;
  endfunction

  function automatic bytes_t ramp(input int n);
    bytes_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    return q;
  endfunction

  // Model: output = (header bytes ++ payload) cut into FW-byte flits; last flit eofc = remaining bytes.
  task automatic build(input logic [HW*8-1:0] hdr, input bytes_t pay);
    bytes_t s;
    s = {};
    for (int b = 0; b < HW; b++) s.push_back(hdr[b*8 +: 8]);
    foreach (pay[i]) s.push_back(pay[i]);
    m_out.delete();
    m_in.delete();
    for (int i = 0; i < s.size(); i += FW) begin
      flit_t f;
      int n;
      n = (s.size() - i < FW) ? s.size() - i : FW;
      f.dat = '0;
      for (int b = 0; b < n; b++) f.dat[b*8 +: 8] = s[i+b];
      f.eofc = (i + FW >= s.size()) ? 8'(n) : 8'd0;
      m_out.push_back(f);
    end
    for (int i = 0; i < pay.size(); i += FW) begin
      flit_t f;
      int n;
      n = (pay.size() - i < FW) ? pay.size() - i : FW;
      f.dat = '0;
      for (int b = 0; b < n; b++) f.dat[b*8 +: 8] = pay[i+b];
      f.eofc = (i + FW >= pay.size()) ? 8'(n) : 8'd0;
      m_in.push_back(f);
    end
  endtask

  task automatic enqueue(input logic [HW*8-1:0] hdr, input bit with_hdr);
    if (with_hdr) hdr_q.push_back(hdr);
    foreach (m_in[i]) in_q.push_back(m_in[i]);
    foreach (m_out[i]) exp_q.push_back(m_out[i]);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || in_q.size() > 0 || hdr_q.size() > 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_i({name, "_drain_left"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // Flit source: holds Ready/data until a transfer (Ready & !Stop at a rising edge).
  initial forever begin
    @(negedge clk);
    if (!arst_n) begin
      smiInReady = 1'b0;
      in_xfer = 1'b0;
    end else begin
      if (in_xfer && in_q.size() > 0) begin
        void'(in_q.pop_front());
        if (in_cyc < 0) in_cyc = cyc;
      end
      if (!smiInReady || in_xfer) begin
        if (in_q.size() > 0 && !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct)) begin
          smiInReady = 1'b1;
          smiInData  = in_q[0].dat;
          smiInEofc  = in_q[0].eofc | (eofc_junk ? 8'hE0 : 8'h00);
        end else begin
          smiInReady = 1'b0;
        end
      end
      in_xfer = smiInReady && !smiInStop;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!arst_n) begin
      headerReady = 1'b0;
      hdr_xfer = 1'b0;
    end else begin
      if (hdr_xfer && hdr_q.size() > 0) void'(hdr_q.pop_front());
      if (!headerReady || hdr_xfer) begin
        if (hdr_q.size() > 0 && !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct)) begin
          headerReady = 1'b1;
          headerData  = hdr_q[0];
        end else begin
          headerReady = 1'b0;
        end
      end
      hdr_xfer = headerReady && !headerStop;
    end
  end

  // Single compare process: every accepted output flit is checked against the model queue.
  initial forever begin
    @(negedge clk);
    smiOutStop = (stop_pct > 0) && ($urandom_range(0, 99) < stop_pct);
    if (arst_n && smiOutReady && rdy_cyc < 0) rdy_cyc = cyc;
    if (arst_n && smiOutReady && !smiOutStop) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_flit actual eofc=%0d data=%h required no flit", smiOutEofc, smiOutData);
      end else begin
        flit_t e, a, r;
        logic [FW*8-1:0] m;
        e = exp_q.pop_front();
        m = valid_mask(e.eofc);
        a.dat = smiOutData & m;
        a.eofc = smiOutEofc;
        r.dat = e.dat & m;
        r.eofc = e.eofc;
        check_f("out_flit", a, r);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HW*8-1:0] hdr;
    bytes_t pay;

    repeat (3) @(negedge clk);
    check_i("rst_out_ready", int'(smiOutReady), 0);
    check_i("rst_in_stop", int'(smiInStop), 0);
    check_i("rst_hdr_stop", int'(headerStop), 0);
    check_i("rst_out_eofc", int'(smiOutEofc), 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single flit, eofc 8
    hdr = 32'hDEADBEEF;
    build(hdr, ramp(8));
    check_i("m1_nflits", m_out.size(), 1);
    check_i("m1_eofc", int'(m_out[0].eofc), 12);
    check_i("m1_hdr_bytes", int'(m_out[0].dat[31:0]), 32'hDEADBEEF);
    check_i("m1_pay_lo", int'(m_out[0].dat[63:32]), 32'h03020100);
    check_i("m1_pay_hi", int'(m_out[0].dat[95:64]), 32'h07060504);
    in_cyc = -1;
    rdy_cyc = -1;
    enqueue(hdr, 1'b1);
    drain("t1", 200);
    check_i("t1_latency", rdy_cyc - in_cyc, 2);

    // 2: eofc 12 exactly fills the output flit
    build(hdr, ramp(12));
    check_i("m2_nflits", m_out.size(), 1);
    check_i("m2_eofc", int'(m_out[0].eofc), 16);
    enqueue(hdr, 1'b1);
    drain("t2", 200);

    // 3: eofc 13 spills one byte into a tail flit
    build(hdr, ramp(13));
    check_i("m3_nflits", m_out.size(), 2);
    check_i("m3_eofc0", int'(m_out[0].eofc), 0);
    check_i("m3_eofc1", int'(m_out[1].eofc), 1);
    check_i("m3_tail_b0", int'(m_out[1].dat[7:0]), 12);
    enqueue(hdr, 1'b1);
    drain("t3", 200);

    // 4: three full flits
    build(hdr, ramp(48));
    check_i("m4_nflits", m_out.size(), 4);
    check_i("m4_eofcs", int'({m_out[0].eofc, m_out[1].eofc, m_out[2].eofc, m_out[3].eofc}), 4);
    check_i("m4_last_bytes", int'(m_out[3].dat[31:0]), 32'h2F2E2D2C);
    enqueue(hdr, 1'b1);
    drain("t4", 200);

    // 5: flits with no header stall the input
    hdr = 32'hCAFEF00D;
    build(hdr, ramp(20));
    enqueue(hdr, 1'b0);
    repeat (20) @(negedge clk);
    check_i("t5_in_stop", int'(smiInStop), 1);
    check_i("t5_no_out", int'(smiOutReady), 0);
    hdr_q.push_back(hdr);
    drain("t5", 200);

    // 6: random frames with random gaps and output backpressure
    gap_pct = 30;
    stop_pct = 50;
    eofc_junk = 1'b1;
    for (int f = 0; f < 200; f++) begin
      int len;
      len = $urandom_range(1, 60);
      pay = {};
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
      hdr = $urandom;
      build(hdr, pay);
      enqueue(hdr, 1'b1);
    end
    drain("t6", 40000);
    gap_pct = 0;
    stop_pct = 0;
    eofc_junk = 1'b0;

    // 7: reset mid-frame, then a clean frame
    hdr = 32'h01234567;
    build(hdr, ramp(64));
    enqueue(hdr, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    check_i("t7_rst_out_ready", int'(smiOutReady), 0);
    check_i("t7_rst_in_stop", int'(smiInStop), 0);
    check_i("t7_rst_hdr_stop", int'(headerStop), 0);
    in_q.delete();
    hdr_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    hdr = 32'h89ABCDEF;
    build(hdr, ramp(29));
    enqueue(hdr, 1'b1);
    drain("t7", 200);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
